// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU blocks.
// Encoding 2'd3 is never entered; the FSM decodes it as idle.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : serial_alu_pkg

// File: rtl/serial_adder_seq_cgen.sv
// Carry-generate cell: cout = majority(ain, bin, cin).
// Latency: combinational. Backpressure: none.
// Behavioural model of the switch-level cell so the block synthesises and lints in RTL builds.
module cgen_mos (
    input  logic ain,
    input  logic bin,
    input  logic cin,
    output logic cout
);

    assign cout = (ain & bin) | (ain & cin) | (bin & cin);

endmodule : cgen_mos

// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single carry cell.
// Latency: out_valid rises WIDTH edges after the accepting edge.
// Backpressure: result held in DONE while out_ready=0; in_ready only in IDLE.
module serial_adder_seq
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic             w_maj;
    logic             w_s;
    logic             w_idle;

    // Anything other than RUN/DONE (including the unused 2'd3) behaves as IDLE.
    assign w_idle    = (r_state != S_RUN) && (r_state != S_DONE);
    assign in_ready  = w_idle;
    assign out_valid = (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

    assign w_s = r_a_sr[0] ^ r_b_sr[0] ^ r_c;

    cgen_mos u_cgen (
        .ain  (r_a_sr[0]),
        .bin  (r_b_sr[0]),
        .cin  (r_c),
        .cout (w_maj)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_c    <= w_maj;
                    r_sum  <= {w_s, r_sum[WIDTH-1:1]};
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    if (r_cnt == LAST) begin
                        // r_c is the carry into the MSB, w_maj the carry out of it.
                        r_cout  <= w_maj;
                        r_ovf   <= r_c ^ w_maj;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        r_a_sr  <= op_a;
                        r_b_sr  <= op_b ^ {WIDTH{sub}};
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
            endcase
        end
    end

endmodule : serial_adder_seq
